vec_chunk_buffer: RTL and testbench
===================================

Name: vec_chunk_buffer

Overview:
- Double-banked inter-layer vector buffer for the mlops pipeline.
- Write side: collects one NBits element per wr_en pulse from an upstream layer; wr_en/wr_data connect to the upstream layer's req_chunk_out/write_out_data.
- Read side: serves WorkingRegs-wide chunks to a downstream matmul/gemm layer, which drives req_chunk_in, req_chunk_ptr_rst and out_vector_valid.
- Upstream can fill vector N+1 while downstream consumes vector N.

Parameters:
- VecLength, 16, elements per vector.
- WorkingRegs, 4, elements per read chunk.
- NBits, 12, element width (signed fixed-point 4.8).

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  synchronous reset, active-high.
- wr_en  in  1  write one element this cycle.
- wr_data  in  NBits  signed element, sampled when wr_en=1.
- wr_ready  out  1  current write bank is not full.
- in_data_ready  out  1  current read bank holds a complete vector.
- in_data  out  WorkingRegs*NBits  chunk at the read pointer; element i is at bits [i*NBits +: NBits].
- req_chunk_in  in  1  advance read pointer one chunk.
- req_chunk_ptr_rst  in  1  rewind read pointer to chunk 0.
- rd_release  in  1  consumer finished the vector (its out_vector_valid pulse).
- overflow  out  1  sticky: a write was attempted while wr_ready=0.

Behaviour:
- Constants:
  - NumChunks = ceil(VecLength/WorkingRegs).
  - Storage: 2 banks x NumChunks*WorkingRegs elements, held in registers (not BRAM).
- Per-bank state: full flag. Pointers: wb (write bank), rb (read bank), wr_idx (0..VecLength-1), rd_chunk (0..NumChunks-1).
- Reset (rst_in=1 at a clock edge, including mid-operation):
  - Pointers/flags: wb=rb=0, wr_idx=0, rd_chunk=0, both full=0, overflow=0.
  - Outputs: wr_ready=1, in_data_ready=0.
  - Stored data: cleared to 0.
- Write:
  - wr_en && wr_ready: write element wr_idx of bank wb, then wr_idx+1.
  - Write to wr_idx==VecLength-1: set full[wb], toggle wb, wr_idx=0.
  - wr_en && !wr_ready: data dropped, overflow<=1 (held until reset).
- Read:
  - in_data is combinational from bank rb at rd_chunk.
  - Chunk elements with index >= VecLength read as 0 (tail zero-pad).
  - in_data is all zeros when in_data_ready=0.
  - Pointer changes are visible on in_data the cycle after the request edge.
- Pointer update priority, per cycle:
  1. rd_release && in_data_ready: full[rb]<=0, toggle rb, rd_chunk<=0.
  2. else req_chunk_ptr_rst: rd_chunk<=0.
  3. else req_chunk_in: rd_chunk<=(rd_chunk==NumChunks-1)?0:rd_chunk+1 (wrap).
- rd_release while in_data_ready=0: ignored, no error.
- Requests while in_data_ready=0: pointer still moves; in_data stays 0.
- Simultaneous write completion and rd_release: banks are independent, both take effect.
  - Example: both banks full, release rb=0 with a write in flight → full[0] clears; wr_ready rises next cycle.
- Output timing: wr_ready = !full[wb] and in_data_ready = full[rb], both registered-state derived, with no combinational path from inputs.
- Throughput:
  - One element written per cycle sustained while the other bank is being read.
  - Earliest in_data_ready rise: the cycle after the VecLength-th write.

Decomposition:
- Package mlops_pkg: chunk_t typedef (packed [WorkingRegs-1:0][NBits-1:0] signed); clog2-derived pointer widths; NumChunks helper function.
- Sub-module vec_bank:
  - One bank's storage, single write port, chunk-wide combinational read with zero-pad.
  - Instantiated twice.
  - Top level keeps pointers, full flags and overflow.

Test Plan:
1. Reset, then 16 writes (values 1..16), no reads → in_data_ready=1 the cycle after write 16; in_data={4,3,2,1} (element0=1); wr_ready stays 1 (bank1 empty).
2. From 1: req_chunk_in x3 → in_data {8,7,6,5}, {12,11,10,9}, {16,15,14,13}; a 4th req_chunk_in wraps to {4,3,2,1}; req_chunk_ptr_rst from chunk 2 → {4,3,2,1}.
3. Fill both banks (1..16, then 101..116), then a 33rd write → wr_ready=0, overflow=1; pulse rd_release → in_data becomes {104,103,102,101}, wr_ready=1 next cycle.
4. VecLength=10, WorkingRegs=4, write 1..10 → chunk 2 reads {0,0,10,9}; NumChunks=3 wrap verified.
5. Same cycle rd_release + req_chunk_in + req_chunk_ptr_rst → rd_chunk=0 on the new bank; rd_release while in_data_ready=0 → no state change.
6. Assert rst_in mid-fill (after 7 writes) → next cycle in_data_ready=0, wr_ready=1, overflow=0; 16 new writes then fill bank0 from index 0.

Source files
------------

// File: rtl/mlops_pkg.sv
// Shared types, default sizes and sizing helpers for the mlops vector buffers.
package mlops_pkg;

  localparam int VEC_LENGTH   = 16;
  localparam int WORKING_REGS = 4;
  localparam int N_BITS       = 12;

  // One read chunk at the default sizes: element i in slot [i].
  typedef logic signed [WORKING_REGS-1:0][N_BITS-1:0] chunk_t;

  // Number of chunks needed to cover a vector (last chunk may be zero-padded).
  function automatic int num_chunks(input int vec_length, input int working_regs);
    return (vec_length + working_regs - 1) / working_regs;
  endfunction

  // Pointer width able to index 0..depth-1, never narrower than one bit.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/vec_bank.sv
// One vector bank: register storage, single write port, chunk-wide read
// with zero padding for element slots beyond the end of the vector.
module vec_bank
  import mlops_pkg::*;
#(
  parameter int VecLength   = VEC_LENGTH,
  parameter int WorkingRegs = WORKING_REGS,
  parameter int NBits       = N_BITS,
  localparam int NumChunks  = num_chunks(VecLength, WorkingRegs),
  localparam int IdxW       = ptr_width(VecLength),
  localparam int ChunkW     = ptr_width(NumChunks)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         wr_en,
  input  logic [IdxW-1:0]              wr_idx,
  input  logic [NBits-1:0]             wr_data,
  input  logic [ChunkW-1:0]            rd_chunk,
  output logic [WorkingRegs*NBits-1:0] rd_data
);

  logic [NBits-1:0] mem_q [VecLength];
  logic [NBits-1:0] mem_d [VecLength];

  // Next storage contents: only the addressed element changes on a write.
  always_comb begin
    for (int i = 0; i < VecLength; i++) begin
      mem_d[i] = (wr_en && (wr_idx == IdxW'(i))) ? wr_data : mem_q[i];
    end
  end

  // Storage registers, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < VecLength; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Chunk read: each real element lands in its slot when its chunk is selected;
  // slots past the vector end are never driven and stay zero.
  always_comb begin
    rd_data = '0;
    for (int e = 0; e < VecLength; e++) begin
      rd_data[(e % WorkingRegs)*NBits +: NBits] =
        rd_data[(e % WorkingRegs)*NBits +: NBits] |
        (mem_q[e] & {NBits{rd_chunk == ChunkW'(e / WorkingRegs)}});
    end
  end

endmodule

// File: rtl/vec_chunk_buffer.sv
// Double-banked inter-layer vector buffer: upstream fills one bank element by
// element while downstream reads the other bank chunk by chunk.
module vec_chunk_buffer
  import mlops_pkg::*;
#(
  parameter int VecLength   = VEC_LENGTH,
  parameter int WorkingRegs = WORKING_REGS,
  parameter int NBits       = N_BITS
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         wr_en,
  input  logic [NBits-1:0]             wr_data,
  output logic                         wr_ready,
  output logic                         in_data_ready,
  output logic [WorkingRegs*NBits-1:0] in_data,
  input  logic                         req_chunk_in,
  input  logic                         req_chunk_ptr_rst,
  input  logic                         rd_release,
  output logic                         overflow
);

  localparam int NumChunks = num_chunks(VecLength, WorkingRegs);
  localparam int IdxW      = ptr_width(VecLength);
  localparam int ChunkW    = ptr_width(NumChunks);
  localparam logic [IdxW-1:0]   LastIdx   = IdxW'(VecLength - 1);
  localparam logic [ChunkW-1:0] LastChunk = ChunkW'(NumChunks - 1);

  logic              wb_q, wb_d;
  logic              rb_q, rb_d;
  logic [IdxW-1:0]   wr_idx_q, wr_idx_d;
  logic [ChunkW-1:0] rd_chunk_q, rd_chunk_d;
  logic [1:0]        full_q, full_d;
  logic              overflow_q, overflow_d;

  logic                         wr_fire_s;
  logic                         rel_fire_s;
  logic [1:0]                   bank_we_s;
  logic [WorkingRegs*NBits-1:0] bank_rd_s [2];

  // Handshake outputs come straight from state flops, never from inputs.
  assign wr_ready      = ~full_q[wb_q];
  assign in_data_ready = full_q[rb_q];
  assign overflow      = overflow_q;
  assign wr_fire_s     = wr_en & ~full_q[wb_q];
  assign rel_fire_s    = rd_release & full_q[rb_q];
  assign in_data       = full_q[rb_q] ? bank_rd_s[rb_q] : '0;

  // Next pointers and flags; write completion and release touch different
  // banks, so both may update full_d in the same cycle.
  always_comb begin
    wb_d       = wb_q;
    rb_d       = rb_q;
    wr_idx_d   = wr_idx_q;
    rd_chunk_d = rd_chunk_q;
    full_d     = full_q;
    overflow_d = overflow_q;

    if (wr_fire_s) begin
      if (wr_idx_q == LastIdx) begin
        full_d[wb_q] = 1'b1;
        wb_d         = ~wb_q;
        wr_idx_d     = '0;
      end else begin
        wr_idx_d = wr_idx_q + IdxW'(1);
      end
    end else if (wr_en) begin
      overflow_d = 1'b1;
    end else begin
      overflow_d = overflow_q;
    end

    if (rel_fire_s) begin
      full_d[rb_q] = 1'b0;
      rb_d         = ~rb_q;
      rd_chunk_d   = '0;
    end else if (req_chunk_ptr_rst) begin
      rd_chunk_d = '0;
    end else if (req_chunk_in) begin
      rd_chunk_d = (rd_chunk_q == LastChunk) ? '0 : rd_chunk_q + ChunkW'(1);
    end else begin
      rd_chunk_d = rd_chunk_q;
    end
  end

  // Pointer and flag registers with synchronous reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      wr_idx_q   <= '0;
      rd_chunk_q <= '0;
      full_q     <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      wb_q       <= wb_d;
      rb_q       <= rb_d;
      wr_idx_q   <= wr_idx_d;
      rd_chunk_q <= rd_chunk_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_we_s[b] = wr_fire_s & (wb_q == 1'(b));

    vec_bank #(
      .VecLength   (VecLength),
      .WorkingRegs (WorkingRegs),
      .NBits       (NBits)
    ) u_bank (
      .clk_in   (clk_in),
      .rst_in   (rst_in),
      .wr_en    (bank_we_s[b]),
      .wr_idx   (wr_idx_q),
      .wr_data  (wr_data),
      .rd_chunk (rd_chunk_q),
      .rd_data  (bank_rd_s[b])
    );
  end

endmodule

// File: tb/tb_vec_chunk_buffer.sv
// Self-checking bench for vec_chunk_buffer: directed table, corner sequences,
// random traffic against a queue-based model, and a VecLength=10 instance.
module tb_vec_chunk_buffer;

  localparam int VL   = 16;
  localparam int WR   = 4;
  localparam int NB   = 12;
  localparam int NC   = 4;
  localparam int VL_B = 10;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic          rst_a, wr_en_a, req_a, prst_a, rel_a;
  logic [NB-1:0] wd_a;
  logic          wrdy_a, rdy_a, ovf_a;
  logic [WR*NB-1:0] data_a;

  logic          rst_b, wr_en_b, req_b, prst_b, rel_b;
  logic [NB-1:0] wd_b;
  logic          wrdy_b, rdy_b, ovf_b;
  logic [WR*NB-1:0] data_b;

  int n_checks = 0;
  int n_fail   = 0;

  vec_chunk_buffer #(.VecLength(VL), .WorkingRegs(WR), .NBits(NB)) dut_a (
    .clk_in(clk_in), .rst_in(rst_a), .wr_en(wr_en_a), .wr_data(wd_a),
    .wr_ready(wrdy_a), .in_data_ready(rdy_a), .in_data(data_a),
    .req_chunk_in(req_a), .req_chunk_ptr_rst(prst_a), .rd_release(rel_a),
    .overflow(ovf_a));

  vec_chunk_buffer #(.VecLength(VL_B), .WorkingRegs(WR), .NBits(NB)) dut_b (
    .clk_in(clk_in), .rst_in(rst_b), .wr_en(wr_en_b), .wr_data(wd_b),
    .wr_ready(wrdy_b), .in_data_ready(rdy_b), .in_data(data_b),
    .req_chunk_in(req_b), .req_chunk_ptr_rst(prst_b), .rd_release(rel_b),
    .overflow(ovf_b));

  // Reference model: completed vectors queued oldest-first, plus the partial one.
  logic [NB-1:0] m_full[$];
  logic [NB-1:0] m_cur[$];
  int            m_chunk = 0;
  bit            m_ovf   = 1'b0;

  typedef struct {
    bit            rst, wr, req, prst, rel;
    logic [NB-1:0] d;
    bit            e_wrdy, e_rdy, e_ovf;
    logic [WR*NB-1:0] e_data;
  } vec_t;

  vec_t tbl[24];

  function automatic logic [WR*NB-1:0] mk(input int e0, input int e1, input int e2, input int e3);
    return {e3[NB-1:0], e2[NB-1:0], e1[NB-1:0], e0[NB-1:0]};
  endfunction

  function automatic vec_t row(input bit rst, input bit wr, input int d, input bit req,
                               input bit prst, input bit rel, input bit ewr,
                               input bit erdy, input bit eovf, input logic [WR*NB-1:0] ed);
    vec_t v;
    v.rst = rst; v.wr = wr; v.d = d[NB-1:0]; v.req = req; v.prst = prst; v.rel = rel;
    v.e_wrdy = ewr; v.e_rdy = erdy; v.e_ovf = eovf; v.e_data = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WR*NB-1:0] model_data();
    logic [WR*NB-1:0] r = '0;
    if (m_full.size() >= VL) begin
      for (int i = 0; i < WR; i++) begin
        if (m_chunk*WR + i < VL) r[i*NB +: NB] = m_full[m_chunk*WR + i];
      end
    end
    return r;
  endfunction

  // Advance the model by one clock edge using the pre-edge state.
  task automatic model_step(input bit rst, input bit wr, input logic [NB-1:0] d,
                            input bit req, input bit prst, input bit rel);
    int  cnt;
    bit  rdy, wrdy;
    if (rst) begin
      m_full.delete(); m_cur.delete(); m_chunk = 0; m_ovf = 1'b0;
    end else begin
      cnt  = m_full.size() / VL;
      rdy  = (cnt > 0);
      wrdy = (cnt < 2);
      if (rel && rdy) begin
        repeat (VL) void'(m_full.pop_front());
        m_chunk = 0;
      end else if (prst) begin
        m_chunk = 0;
      end else if (req) begin
        m_chunk = (m_chunk + 1) % NC;
      end
      if (wr) begin
        if (wrdy) begin
          m_cur.push_back(d);
          if (m_cur.size() == VL) begin
            foreach (m_cur[i]) m_full.push_back(m_cur[i]);
            m_cur.delete();
          end
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // One cycle on dut_a: drive, clock, then compare every output with the model.
  task automatic cyc_a(input bit rst, input bit wr, input logic [NB-1:0] d,
                       input bit req, input bit prst, input bit rel);
    rst_a = rst; wr_en_a = wr; wd_a = d; req_a = req; prst_a = prst; rel_a = rel;
    model_step(rst, wr, d, req, prst, rel);
    @(posedge clk_in);
    #1;
    chk("model_wr_ready", wrdy_a, (m_full.size() < 2*VL));
    chk("model_in_data_ready", rdy_a, (m_full.size() >= VL));
    chk("model_overflow", ovf_a, m_ovf);
    chk("model_in_data", data_a, model_data());
  endtask

  task automatic cyc_b(input bit rst, input bit wr, input logic [NB-1:0] d,
                       input bit req, input bit prst, input bit rel);
    rst_b = rst; wr_en_b = wr; wd_b = d; req_b = req; prst_b = prst; rel_b = rel;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    rst_a = 1'b1; wr_en_a = 1'b0; wd_a = '0; req_a = 1'b0; prst_a = 1'b0; rel_a = 1'b0;
    rst_b = 1'b1; wr_en_b = 1'b0; wd_b = '0; req_b = 1'b0; prst_b = 1'b0; rel_b = 1'b0;

    // Directed table: reset, fill bank 0 with 1..16, walk/wrap/rewind chunks.
    tbl[0] = row(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    for (int k = 1; k <= 16; k++) begin
      tbl[k] = row(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0, 1'b1, (k == 16), 1'b0,
                   (k == 16) ? mk(1, 2, 3, 4) : '0);
    end
    tbl[17] = row(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(5, 6, 7, 8));
    tbl[18] = row(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(9, 10, 11, 12));
    tbl[19] = row(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(13, 14, 15, 16));
    tbl[20] = row(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(1, 2, 3, 4));
    tbl[21] = row(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(5, 6, 7, 8));
    tbl[22] = row(1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, mk(9, 10, 11, 12));
    tbl[23] = row(1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, mk(1, 2, 3, 4));

    for (int k = 0; k < 24; k++) begin
      cyc_a(tbl[k].rst, tbl[k].wr, tbl[k].d, tbl[k].req, tbl[k].prst, tbl[k].rel);
      chk($sformatf("tbl%0d_wr_ready", k), wrdy_a, tbl[k].e_wrdy);
      chk($sformatf("tbl%0d_in_data_ready", k), rdy_a, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_overflow", k), ovf_a, tbl[k].e_ovf);
      chk($sformatf("tbl%0d_in_data", k), data_a, tbl[k].e_data);
    end

    // Both banks full, then overflow, then release.
    for (int k = 1; k <= 16; k++) cyc_a(1'b0, 1'b1, NB'(100 + k), 1'b0, 1'b0, 1'b0);
    chk("both_full_wr_ready", wrdy_a, 1'b0);
    cyc_a(1'b0, 1'b1, NB'(999), 1'b0, 1'b0, 1'b0);
    chk("ovf_set", ovf_a, 1'b1);
    chk("ovf_wr_ready", wrdy_a, 1'b0);
    cyc_a(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("release_data", data_a, mk(101, 102, 103, 104));
    chk("release_wr_ready", wrdy_a, 1'b1);
    chk("ovf_sticky", ovf_a, 1'b1);

    // Release wins over simultaneous rewind/advance; release while empty is ignored.
    for (int k = 1; k <= 16; k++) cyc_a(1'b0, 1'b1, NB'(200 + k), 1'b0, 1'b0, 1'b0);
    cyc_a(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("bank1_chunk1", data_a, mk(105, 106, 107, 108));
    cyc_a(1'b0, 1'b0, '0, 1'b1, 1'b1, 1'b1);
    chk("combo_release_data", data_a, mk(201, 202, 203, 204));
    cyc_a(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("drained_ready", rdy_a, 1'b0);
    cyc_a(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("idle_release_ready", rdy_a, 1'b0);
    chk("idle_release_wr_ready", wrdy_a, 1'b1);
    chk("idle_release_data", data_a, '0);

    // Reset in the middle of a fill.
    for (int k = 1; k <= 7; k++) cyc_a(1'b0, 1'b1, NB'(50 + k), 1'b0, 1'b0, 1'b0);
    cyc_a(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("midrst_ready", rdy_a, 1'b0);
    chk("midrst_wr_ready", wrdy_a, 1'b1);
    chk("midrst_overflow", ovf_a, 1'b0);
    for (int k = 1; k <= 16; k++) cyc_a(1'b0, 1'b1, NB'(k), 1'b0, 1'b0, 1'b0);
    chk("midrst_refill_data", data_a, mk(1, 2, 3, 4));

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cyc_a(($urandom_range(0, 499) == 0), ($urandom_range(0, 9) < 7),
            NB'($urandom_range(0, 4095)), ($urandom_range(0, 9) < 3),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
    end

    // VecLength=10: three chunks, last one zero-padded.
    cyc_b(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("b_reset_ready", rdy_b, 1'b0);
    chk("b_reset_wr_ready", wrdy_b, 1'b1);
    for (int k = 1; k <= 9; k++) cyc_b(1'b0, 1'b1, NB'(k), 1'b0, 1'b0, 1'b0);
    chk("b_nine_ready", rdy_b, 1'b0);
    cyc_b(1'b0, 1'b1, NB'(10), 1'b0, 1'b0, 1'b0);
    chk("b_ten_ready", rdy_b, 1'b1);
    chk("b_chunk0", data_b, mk(1, 2, 3, 4));
    cyc_b(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("b_chunk1", data_b, mk(5, 6, 7, 8));
    cyc_b(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("b_chunk2_pad", data_b, mk(9, 10, 0, 0));
    cyc_b(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("b_wrap", data_b, mk(1, 2, 3, 4));
    chk("b_overflow", ovf_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
